lfsr_stream_gen: RTL
====================

Name: lfsr_stream_gen

Overview:
- Parametrised successor to the team's fixed 64-bit shift-register random generator.
- Configurable width, tap mask, bits advanced per output word, and counter width.
- Adds a valid/ready output stream, runtime seed loading, all-zero lockup recovery and a delivered-word counter.
- Sits between the analyzer's stimulus/test-pattern logic and any consumer that needs back-pressured pseudo-random words.

Parameters:
- BITS, 64, register and output word width (>=4).
- TAPS, 64'h0000_0000_0000_1008, feedback mask (default taps are bits 3 and 12); only bits [BITS-1:0] are used.
- INITIAL_VALUE, 64'h5083_e3e3_8587_694b, reset and lockup-recovery value. Must be nonzero; an elaboration check enforces this.
- STEP, 1, single-bit LFSR steps applied per delivered word (1..BITS).
- COUNT_W, 32, width of word_count.

Ports:
- clk  in  1  clock; all logic on posedge.
- rs  in  1  synchronous active-high reset; highest priority.
- en  in  1  run enable.
- seed_load  in  1  load seed_data this cycle.
- seed_data  in  BITS  new seed.
- out_ready  in  1  consumer accepts word.
- out_valid  out  1  random_data is a valid word.
- random_data  out  BITS  current register contents (direct, registered).
- lockup_fix  out  1  one-cycle pulse when the all-zero state was replaced.
- word_count  out  COUNT_W  number of accepted words, modulo 2^COUNT_W.

Behaviour:
- Single step: new[0] = XOR of shift_reg[k] over all k where TAPS[k]=1; new[i] = shift_reg[i-1] for i>=1. One "advance" applies STEP single steps, unrolled combinationally, and completes in one cycle.
- Zero guard: any register write whose value would be all-zero writes INITIAL_VALUE instead and sets lockup_fix=1 in the next cycle only. This applies to both advances and seed loads.
- Reset (rs=1 at posedge): shift_reg=INITIAL_VALUE, state=IDLE, out_valid=0, lockup_fix=0, word_count=0. Reset overrides seed_load and any handshake.
- Handshake: a transfer occurs when out_valid && out_ready. On a transfer: shift_reg advances, word_count increments and wraps from all-ones to 0.
- While out_valid=1 with no transfer, random_data and out_valid stay stable. The only exceptions are seed_load and rs.
- FSM states: IDLE, RUN, RELOAD. out_valid=1 only in RUN.
- IDLE: if en=1, go to RUN. The first word offered is the unadvanced current register; no advance happens on entry.
- RUN, transfer with en=1: stay in RUN; the next word is valid in the next cycle (zero-bubble streaming).
- RUN, transfer with en=0: advance, then go to IDLE.
- RUN, no transfer: stay in RUN regardless of en. Deasserting en never withdraws a word.
- Seed load, any state: seed_load=1 writes seed_data (zero guard applies) and goes to RELOAD. It has priority over a same-cycle transfer: no advance and no count increment occur.
- RELOAD: out_valid=0 for exactly one cycle, then go to RUN if en=1, else IDLE. seed_load during RELOAD reloads and stays in RELOAD.
- lockup_fix is 0 in all cycles other than the single pulse cycle.

Decomposition:
- Package lfsr_pkg holds the state enum (IDLE, RUN, RELOAD) and the default TAPS and INITIAL_VALUE constants.
- Sub-module lfsr_advance (combinational) takes in[BITS] and produces out[BITS] after STEP steps, parametrised by BITS, TAPS and STEP. It is shared with future generators.
- Top holds the FSM, register, zero guard and counter.

Test Plan:
- Reset, then en=1, out_ready=1, default params. Word 0 = 0x5083E3E38587694B, word 1 = 0xA107C7C70B0ED297. word_count=1 after the first transfer and 2 after the second.
- out_ready=0 for 5 cycles while in RUN. out_valid=1 and random_data=0x5083E3E38587694B are held constant. word_count stays 0. Drop en mid-stall: the word is still held until accepted, then out_valid=0.
- seed_load with seed_data=0, asserted together with out_ready=1. The register becomes INITIAL_VALUE and lockup_fix pulses for 1 cycle. out_valid=0 for one cycle. word_count is unchanged.
- Seed 0x8000_0000_0000_0000, STEP=1, then accept one word. The next value would be zero, so the register becomes 0x5083E3E38587694B and lockup_fix pulses.
- STEP=64: each accepted word equals the reference model's single-step sequence sampled every 64 steps, checked over 1000 words.
- COUNT_W=4: after 16 transfers, word_count wraps to 0. rs asserted mid-stream returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: types and default constants shared by the LFSR stream generator
// and its combinational advance block.
//   lfsr_state_e        : stream FSM states (IDLE, RUN, RELOAD)
//   LFSR_DEFAULT_TAPS   : default feedback mask (bits 3 and 12)
//   LFSR_DEFAULT_INIT   : default reset / lockup-recovery value
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } lfsr_state_e;

  localparam logic [63:0] LFSR_DEFAULT_TAPS = 64'h0000_0000_0000_1008;
  localparam logic [63:0] LFSR_DEFAULT_INIT = 64'h5083_e3e3_8587_694b;

endpackage : lfsr_pkg

// File: rtl/lfsr_advance.sv
// lfsr_advance: purely combinational block that applies STEP single-bit
// Fibonacci LFSR steps to a register value in one pass.
// One step: new[0] = XOR of in[k] for every k with TAPS[k]=1,
//           new[i] = in[i-1] for i >= 1.
// Ports:
//   i_data [BITS] : current register value
//   o_data [BITS] : value after STEP steps
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int          BITS = 64,
  parameter logic [63:0] TAPS = LFSR_DEFAULT_TAPS,
  parameter int          STEP = 1
) (
  input  logic [BITS-1:0] i_data,
  output logic [BITS-1:0] o_data
);

  localparam logic [BITS-1:0] TAP_MASK = TAPS[BITS-1:0];

  if (BITS < 4) begin : g_bad_bits
    $error("lfsr_advance: BITS must be at least 4");
  end
  if ((STEP < 1) || (STEP > BITS)) begin : g_bad_step
    $error("lfsr_advance: STEP must lie in 1..BITS");
  end

  logic [BITS-1:0] w_work;

  // The loop unrolls into a STEP-deep chain of shift + parity stages.
  always_comb begin
    w_work = i_data;
    for (int k = 0; k < STEP; k++) begin
      w_work = {w_work[BITS-2:0], ^(w_work & TAP_MASK)};
    end
    o_data = w_work;
  end

endmodule : lfsr_advance

// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: back-pressured pseudo-random word source.
// A word is offered on random_data while out_valid is high; a transfer
// (out_valid && out_ready) advances the LFSR by STEP steps and bumps
// word_count. seed_load replaces the register at any time and costs one
// idle cycle (RELOAD). Any write that would leave the register all-zero
// writes INITIAL_VALUE instead and pulses lockup_fix for one cycle.
// Ports:
//   clk         : clock, all logic on posedge
//   rs          : synchronous active-high reset, highest priority
//   en          : run enable
//   seed_load   : load seed_data this cycle
//   seed_data   : new seed [BITS]
//   out_ready   : consumer accepts the offered word
//   out_valid   : random_data holds a valid word
//   random_data : register contents [BITS]
//   lockup_fix  : one-cycle pulse after an all-zero write was replaced
//   word_count  : accepted words modulo 2^COUNT_W
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int          BITS          = 64,
  parameter logic [63:0] TAPS          = LFSR_DEFAULT_TAPS,
  parameter logic [63:0] INITIAL_VALUE = LFSR_DEFAULT_INIT,
  parameter int          STEP          = 1,
  parameter int          COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               rs,
  input  logic               en,
  input  logic               seed_load,
  input  logic [BITS-1:0]    seed_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [BITS-1:0]    random_data,
  output logic               lockup_fix,
  output logic [COUNT_W-1:0] word_count
);

  localparam logic [BITS-1:0]    INIT_VAL = INITIAL_VALUE[BITS-1:0];
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

  if (INITIAL_VALUE[BITS-1:0] == '0) begin : g_bad_init
    $error("lfsr_stream_gen: INITIAL_VALUE must be nonzero");
  end
  if (COUNT_W < 1) begin : g_bad_count
    $error("lfsr_stream_gen: COUNT_W must be at least 1");
  end

  lfsr_state_e        r_state;
  lfsr_state_e        w_state_next;
  logic [BITS-1:0]    r_shift;
  logic [BITS-1:0]    w_shift_next;
  logic [BITS-1:0]    w_advanced;
  logic [BITS-1:0]    w_candidate;
  logic               w_write;
  logic               w_zero;
  logic               w_xfer;
  logic               r_fix;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;

  lfsr_advance #(
    .BITS (BITS),
    .TAPS (TAPS),
    .STEP (STEP)
  ) u_advance (
    .i_data (r_shift),
    .o_data (w_advanced)
  );

  assign w_xfer = (r_state == RUN) && out_ready;

  // Next-state / register-write decode. seed_load wins over a transfer in the
  // same cycle, so a reload never advances the register or counts a word.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_candidate  = r_shift;
    w_count_next = r_count;
    if (seed_load) begin
      w_write      = 1'b1;
      w_candidate  = seed_data;
      w_state_next = RELOAD;
    end else begin
      case (r_state)
        IDLE: begin
          // Entering RUN offers the current register; no advance here.
          if (en) begin
            w_state_next = RUN;
          end
        end
        RUN: begin
          // Without a transfer the word is held even if en drops.
          if (w_xfer) begin
            w_write      = 1'b1;
            w_candidate  = w_advanced;
            w_count_next = r_count + CNT_ONE;
            if (!en) begin
              w_state_next = IDLE;
            end
          end
        end
        RELOAD: begin
          w_state_next = en ? RUN : IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Zero guard: an all-zero register would lock the LFSR forever.
  assign w_zero       = w_write && (w_candidate == '0);
  assign w_shift_next = w_write ? (w_zero ? INIT_VAL : w_candidate) : r_shift;

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_shift <= INIT_VAL;
      r_fix   <= 1'b0;
      r_count <= '0;
    end else begin
      r_shift <= w_shift_next;
      r_fix   <= w_zero;
      r_count <= w_count_next;
    end
  end

  assign out_valid   = (r_state == RUN);
  assign random_data = r_shift;
  assign lockup_fix  = r_fix;
  assign word_count  = r_count;

endmodule : lfsr_stream_gen
